// File: rtl/board_io_pkg.sv
// Shared types and constants for the board I/O controller: step-FSM states,
// mode encoding and the display slice-count helper.
package board_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_REL
    } step_state_t;

    localparam logic MODE_FREE = 1'b0;
    localparam logic MODE_STEP = 1'b1;

    function automatic int unsigned slices(input int unsigned data_w, input int unsigned led_w);
        return data_w / led_w;
    endfunction

endpackage

// File: rtl/board_io_ctrl_sw_debounce.sv
// One-bit input conditioner: 2-flop synchronizer followed by a counter that
// accepts a new level only after DEB_CYC consecutive differing samples.
module sw_debounce
    import board_io_pkg::*;
#(
    parameter int unsigned DEB_CYC = 16
) (
    input  logic clock_in,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int unsigned CNT_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced switches/step button, free-run or single-step
// CPU clock-enable, and LED byte-slice display. Optional: BOARD_IO_HEARTBEAT_EN.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int unsigned SW_W    = 4,
    parameter int unsigned LED_W   = 8,
    parameter int unsigned CH_N    = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEB_CYC = 16,
    parameter logic [23:0] DIV_MAX = 24'd9_999_999
) (
    input  logic                     clock_in,
    input  logic                     reset,
    input  logic [SW_W-1:0]          switch,
    input  logic                     step_btn,
    input  logic [CH_N*DATA_W-1:0]   ch_data,
    output logic [LED_W-1:0]         led,
    output logic                     cpu_clk_en,
    output logic [SW_W-1:0]          sw_stable
);

    localparam int unsigned SLICES = slices(DATA_W, LED_W);
    localparam int unsigned SEL_W  = SW_W - 1;

    logic              step_deb;
    logic              step_q;
    logic              mode_q;
    logic              released;
    logic [23:0]       div;
    logic [23:0]       div_nxt;
    step_state_t       state;
    logic [SEL_W-1:0]  sel;
    int unsigned       sel_ch;
    int unsigned       sel_sl;
    logic [LED_W-1:0]  slice;

    for (genvar i = 0; i < SW_W; i++) begin : g_sw_deb
        sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clock_in (clock_in),
            .reset    (reset),
            .raw      (switch[i]),
            .stable   (sw_stable[i])
        );
    end

    sw_debounce #(.DEB_CYC(DEB_CYC)) u_step_deb (
        .clock_in (clock_in),
        .reset    (reset),
        .raw      (step_btn),
        .stable   (step_deb)
    );

    assign sel     = sw_stable[SW_W-1:1];
    assign div_nxt = (div == DIV_MAX) ? '0 : div + 24'd1;

    // The strobe is registered alongside the divider so it is high exactly
    // while div==DIV_MAX (FREE) or while the FSM sits in PULSE (STEP).
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            released   <= 1'b0;
            div        <= '0;
            cpu_clk_en <= 1'b0;
            state      <= IDLE;
            mode_q     <= MODE_FREE;
            step_q     <= 1'b0;
        end else begin
            released   <= 1'b1;
            mode_q     <= sw_stable[0];
            step_q     <= step_deb;
            cpu_clk_en <= 1'b0;
            if (sw_stable[0] != mode_q) begin
                div   <= '0;
                state <= IDLE;
            end else if (sw_stable[0] == MODE_FREE) begin
                state <= IDLE;
                if (released) begin
                    div        <= div_nxt;
                    cpu_clk_en <= (div_nxt == DIV_MAX);
                end
            end else begin
                div <= '0;
                case (state)
                    IDLE: begin
                        if (step_deb && !step_q) begin
                            state      <= PULSE;
                            cpu_clk_en <= 1'b1;
                        end
                    end
                    PULSE:    state <= WAIT_REL;
                    WAIT_REL: if (!step_deb) state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        sel_ch = 32'(sel) / SLICES;
        sel_sl = 32'(sel) % SLICES;
        slice  = '0;
        if (sel_ch < CH_N) begin
            slice = ch_data[sel_ch*DATA_W + sel_sl*LED_W +: LED_W];
        end
    end

`ifdef BOARD_IO_HEARTBEAT_EN
    logic heartbeat;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            heartbeat <= 1'b0;
            led       <= '0;
        end else begin
            heartbeat <= heartbeat ^ cpu_clk_en;
            led       <= {heartbeat, slice[LED_W-2:0]};
        end
    end
`else
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            led <= '0;
        end else begin
            led <= slice;
        end
    end
`endif

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl (DEB_CYC=4, DIV_MAX=9) with a
// behavioural model of strobe timing, debounce latency and display selection.
module tb_board_io_ctrl;

    localparam int unsigned SW_W    = 4;
    localparam int unsigned LED_W   = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEB_CYC = 4;
    localparam logic [23:0] DIV_MAX = 24'd9;
    localparam int          PERIOD  = 10;      // DIV_MAX + 1
    localparam int          DEB_LAT = 6;       // DEB_CYC + 2

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [SW_W-1:0]        sw = '0;
    logic                   step = 1'b0;
    logic [2*DATA_W-1:0]    ch_data = '0;
    logic [LED_W-1:0]       led, led1;
    logic                   en, en1;
    logic [SW_W-1:0]        sws, sws1;

    int chk = 0;
    int pass = 0;
    int cyc = 0;

    board_io_ctrl #(
        .SW_W(SW_W), .LED_W(LED_W), .CH_N(2), .DATA_W(DATA_W),
        .DEB_CYC(DEB_CYC), .DIV_MAX(DIV_MAX)
    ) dut (
        .clock_in(clk), .reset(rst_n), .switch(sw), .step_btn(step),
        .ch_data(ch_data), .led(led), .cpu_clk_en(en), .sw_stable(sws)
    );

    board_io_ctrl #(
        .SW_W(SW_W), .LED_W(LED_W), .CH_N(1), .DATA_W(DATA_W),
        .DEB_CYC(DEB_CYC), .DIV_MAX(DIV_MAX)
    ) dut1 (
        .clock_in(clk), .reset(rst_n), .switch(sw), .step_btn(step),
        .ch_data(ch_data[DATA_W-1:0]), .led(led1), .cpu_clk_en(en1), .sw_stable(sws1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // The selected slice is simply byte 'sel' of the concatenated channels.
    function automatic logic [7:0] model_led(input logic [63:0] d, input int unsigned s,
                                             input int unsigned chn);
        logic [63:0] sh;
        if (s >= chn * (DATA_W / LED_W)) return 8'h00;
        sh = d >> (LED_W * s);
        return sh[7:0];
    endfunction

    task automatic test_reset();
        logic exp_en;
        rst_n = 1'b0;
        sw = '0;
        step = 1'b0;
        ch_data = {$urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk++; if (en !== 1'b0) $display("FAIL reset_en: got %b expected 0", en); else pass++;
            chk++; if (led !== '0) $display("FAIL reset_led: got %h expected 00", led); else pass++;
            chk++; if (sws !== '0) $display("FAIL reset_sws: got %b expected 0000", sws); else pass++;
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            exp_en = (k % PERIOD == 0);
            chk++;
            if (en !== exp_en) $display("FAIL free_run k=%0d: en=%b expected %b", k, en, exp_en);
            else pass++;
        end
        chk++;
        if (led !== model_led(ch_data, 0, 2))
            $display("FAIL reset_sel0_led: got %h expected %h", led, model_led(ch_data, 0, 2));
        else pass++;
    endtask

    task automatic test_debounce();
        int w;
        for (int seg = 0; seg < 4; seg++) begin
            sw[1] = (seg % 2 == 0);
            w = $urandom_range(1, 3);
            for (int k = 0; k < w; k++) begin
                tick();
                chk++;
                if (sws[1] !== 1'b0) $display("FAIL deb_bounce seg=%0d: sws1=%b expected 0", seg, sws[1]);
                else pass++;
            end
        end
        sw[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk++;
            if (sws[1] !== (k >= DEB_LAT))
                $display("FAIL deb_settle k=%0d: sws1=%b expected %b", k, sws[1], (k >= DEB_LAT));
            else pass++;
        end
    endtask

    task automatic set_sel(input int unsigned s);
        logic [2:0] s3;
        s3 = 3'(s);
        sw = {s3, sw[0]};
        repeat (DEB_LAT + 2) tick();
    endtask

    task automatic test_display();
        int unsigned sels [5] = '{0, 3, 5, 7, 4};
        int unsigned s;
        logic [63:0] old;
        ch_data = {32'hDEADBEEF, 32'h12345678};
        for (int i = 0; i < 5; i++) begin
            set_sel(sels[i]);
            chk++;
            if (led !== model_led(ch_data, sels[i], 2))
                $display("FAIL disp_dir sel=%0d: led=%h expected %h", sels[i], led, model_led(ch_data, sels[i], 2));
            else pass++;
            chk++;
            if (led1 !== model_led({32'h0, ch_data[31:0]}, sels[i], 1))
                $display("FAIL disp_dir_ch1 sel=%0d: led=%h expected %h", sels[i], led1,
                         model_led({32'h0, ch_data[31:0]}, sels[i], 1));
            else pass++;
        end
        for (int i = 0; i < 6; i++) begin
            ch_data = {$urandom, $urandom};
            s = $urandom_range(0, 7);
            set_sel(s);
            chk++;
            if (sws !== sw) $display("FAIL disp_sws: got %b expected %b", sws, sw); else pass++;
            chk++;
            if (led !== model_led(ch_data, s, 2))
                $display("FAIL disp_rand sel=%0d: led=%h expected %h", s, led, model_led(ch_data, s, 2));
            else pass++;
            chk++;
            if (led1 !== model_led({32'h0, ch_data[31:0]}, s, 1))
                $display("FAIL disp_rand_ch1 sel=%0d: led=%h expected %h", s, led1,
                         model_led({32'h0, ch_data[31:0]}, s, 1));
            else pass++;
            old = ch_data;
            ch_data = {$urandom, $urandom};
            chk++;
            if (led !== model_led(old, s, 2))
                $display("FAIL disp_hold sel=%0d: led=%h expected %h", s, led, model_led(old, s, 2));
            else pass++;
            tick();
            chk++;
            if (led !== model_led(ch_data, s, 2))
                $display("FAIL disp_latency sel=%0d: led=%h expected %h", s, led, model_led(ch_data, s, 2));
            else pass++;
        end
    endtask

    task automatic test_step();
        int hold;
        int strobes = 0;
        sw[0] = 1'b1;
        repeat (10) tick();
        chk++; if (sws[0] !== 1'b1) $display("FAIL step_mode: sws0=%b expected 1", sws[0]); else pass++;
        for (int p = 0; p < 2; p++) begin
            step = 1'b1;
            hold = $urandom_range(30, 60);
            for (int k = 1; k <= hold; k++) begin
                tick();
                strobes += int'(en);
                chk++;
                if (en !== (k == DEB_LAT + 1))
                    $display("FAIL step_press p=%0d k=%0d: en=%b expected %b", p, k, en, (k == DEB_LAT + 1));
                else pass++;
            end
            step = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                tick();
                strobes += int'(en);
                chk++;
                if (en !== 1'b0) $display("FAIL step_release p=%0d k=%0d: en=%b expected 0", p, k, en);
                else pass++;
            end
        end
        chk++;
        if (strobes != 2) $display("FAIL step_count: got %0d strobes expected 2", strobes); else pass++;
    endtask

    task automatic test_mode_change();
        int c0, f1, r1, f2, gap;
        logic exp_en;
        c0 = cyc;
        f1 = c0 + DEB_LAT;
        r1 = 1 << 30;
        f2 = 1 << 30;
        gap = $urandom_range(3, 12);
        step = 1'b0;
        sw[0] = 1'b0;
        while (cyc < c0 + 200 && cyc < f2 + 25) begin
            tick();
            exp_en = 1'b0;
            if (cyc > f1 && cyc <= r1 && (cyc - f1) % PERIOD == 0) exp_en = 1'b1;
            if (cyc > f2 && (cyc - f2) % PERIOD == 0) exp_en = 1'b1;
            chk++;
            if (en !== exp_en) $display("FAIL mode_change n=%0d: en=%b expected %b", cyc - c0, en, exp_en);
            else pass++;
            // Drive to STEP so the debounced change lands while the divider reads 5.
            if (cyc == f1 + PERIOD) begin
                sw[0] = 1'b1;
                r1 = cyc + DEB_LAT;
            end
            if (cyc == r1 + gap) begin
                sw[0] = 1'b0;
                f2 = cyc + DEB_LAT;
            end
        end
        chk++;
        if (f2 >= (1 << 30)) $display("FAIL mode_change_bound: second FREE entry %0d expected < %0d", f2, 1 << 30);
        else pass++;
    endtask

    task automatic test_reset_mid_pulse();
        sw[0] = 1'b1;
        step = 1'b0;
        repeat (10) tick();
        step = 1'b1;
        repeat (DEB_LAT + 1) tick();
        chk++; if (en !== 1'b1) $display("FAIL rmp_pulse: en=%b expected 1", en); else pass++;
        #2;
        rst_n = 1'b0;
        #1;
        chk++; if (en !== 1'b0) $display("FAIL rmp_async_en: en=%b expected 0", en); else pass++;
        chk++; if (sws !== '0) $display("FAIL rmp_async_sws: got %b expected 0000", sws); else pass++;
        chk++; if (led !== '0) $display("FAIL rmp_async_led: got %h expected 00", led); else pass++;
        step = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk++;
            if (en !== 1'b0) $display("FAIL rmp_after k=%0d: en=%b expected 0", k, en); else pass++;
        end
        step = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk++;
            if (en !== (k == DEB_LAT + 1))
                $display("FAIL rmp_idle_press k=%0d: en=%b expected %b", k, en, (k == DEB_LAT + 1));
            else pass++;
        end
        step = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_display();
        test_step();
        test_mode_change();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
